// File: rtl/alarm_bank.sv
// ---------------------------------------------------------------------------
// alarm_bank
//
// Multi-slot alarm controller. Holds NUM_ALARMS independently armed BCD
// alarm times, compares them against the running clock on every minute
// tick, and runs a single IDLE/RING/SNOOZE state machine that handles
// snooze, dismiss and the unanswered-ring auto timeout. While ringing it
// produces a blinking alarm LED.
//
// Ports:
//   clk_i        system clock, everything on the rising edge
//   rst_i        synchronous active-low reset
//   HT_i..MU_i   current time, BCD hour tens/units, minute tens/units
//   min_tick_i   one-cycle pulse, time inputs already show the new minute
//   wr_en_i      one-cycle strobe to write an alarm slot
//   wr_idx_i     slot being written
//   wr_time_i    {HT,HU,MT,MU} BCD alarm time for the slot
//   wr_arm_i     enable bit stored with the slot
//   snooze_i     one-cycle snooze request (debounced button)
//   dismiss_i    one-cycle dismiss request (debounced button)
//   armed_o      per-slot enable bits
//   ringing_o    high while ringing
//   snoozing_o   high while snoozed
//   ring_idx_o   slot currently ringing or snoozed
//   led_alarm_o  blinking alarm indicator
//   wr_err_o     one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
module alarm_bank #(
    parameter int NUM_ALARMS       = 4,
    parameter int IDX_W            = 2,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int BLINK_DIV        = 50000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            HT_i,
    input  logic [3:0]            HU_i,
    input  logic [3:0]            MT_i,
    input  logic [3:0]            MU_i,
    input  logic                  min_tick_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [15:0]           wr_time_i,
    input  logic                  wr_arm_i,
    input  logic                  snooze_i,
    input  logic                  dismiss_i,
    output logic [NUM_ALARMS-1:0] armed_o,
    output logic                  ringing_o,
    output logic                  snoozing_o,
    output logic [IDX_W-1:0]      ring_idx_o,
    output logic                  led_alarm_o,
    output logic                  wr_err_o
);

    localparam int              BLINK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [3:0]      SNOOZE_LOAD  = 4'(SNOOZE_MIN);
    localparam logic [3:0]      TIMEOUT_LAST = 4'(RING_TIMEOUT_MIN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    logic [15:0]           slotTime_q [NUM_ALARMS];
    logic [15:0]           slotTime_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed_q;
    logic [NUM_ALARMS-1:0] armed_d;
    logic                  wrErr_q;

    logic [15:0]           curTime;
    logic                  wrTimeValid;
    logic                  wrIdxValid;
    logic                  wrAccept;
    logic                  disarmHit;
    logic                  matchFound;
    logic [IDX_W-1:0]      matchIdx;

    state_t                state_q;
    logic                  ringing_q;
    logic                  snoozing_q;
    logic                  led_q;
    logic [IDX_W-1:0]      ringIdx_q;
    logic [3:0]            timeoutCnt_q;
    logic [3:0]            snoozeCnt_q;
    logic [BLINK_W-1:0]    blinkCnt_q;

    // Write qualification: the time must be a real 24-hour BCD time and the
    // index must name an existing slot. A write that disarms the slot that
    // is currently ringing or snoozed cancels the alarm.
    always_comb begin
        curTime     = {HT_i, HU_i, MT_i, MU_i};
        wrTimeValid = (wr_time_i[15:12] <= 4'd2) &&
                      (wr_time_i[11:8]  <= 4'd9) &&
                      !((wr_time_i[15:12] == 4'd2) && (wr_time_i[11:8] > 4'd3)) &&
                      (wr_time_i[7:4]   <= 4'd5) &&
                      (wr_time_i[3:0]   <= 4'd9);
        wrIdxValid  = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr_idx_i == IDX_W'(i)) begin
                wrIdxValid = 1'b1;
            end
        end
        wrAccept  = wr_en_i && wrTimeValid && wrIdxValid;
        disarmHit = wrAccept && !wr_arm_i && (wr_idx_i == ringIdx_q);
    end

    // Alarm match on the minute tick. Scanning from the top slot down lets
    // the lowest matching index overwrite the others, so it wins. Because
    // matching only happens on the tick, a slot cannot retrigger within the
    // same minute.
    always_comb begin
        matchFound = 1'b0;
        matchIdx   = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (min_tick_i && armed_q[i] && (slotTime_q[i] == curTime)) begin
                matchFound = 1'b1;
                matchIdx   = IDX_W'(i);
            end
        end
    end

    // Next contents of the slot storage: only an accepted write touches it.
    always_comb begin
        slotTime_d = slotTime_q;
        armed_d    = armed_q;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wrAccept && (wr_idx_i == IDX_W'(i))) begin
                slotTime_d[i] = wr_time_i;
                armed_d[i]    = wr_arm_i;
            end
        end
    end

    // Slot storage plus the rejected-write pulse, which is high for exactly
    // the cycle after the bad write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slotTime_q <= '{default: '0};
            armed_q    <= '0;
            wrErr_q    <= 1'b0;
        end else begin
            slotTime_q <= slotTime_d;
            armed_q    <= armed_d;
            wrErr_q    <= wr_en_i && !wrAccept;
        end
    end

    // Ring state machine with registered outputs. A match always wins and
    // (re)enters RING with fresh counters and a fresh blink phase. Below
    // that, dismiss or a disarming write ends the alarm, then snooze, then
    // the minute counters expire. The LED starts lit on every RING entry and
    // toggles each BLINK_DIV cycles; it is dark outside RING.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            led_q        <= 1'b0;
            ringIdx_q    <= '0;
            timeoutCnt_q <= '0;
            snoozeCnt_q  <= '0;
            blinkCnt_q   <= '0;
        end else if (matchFound) begin
            state_q      <= RING;
            ringing_q    <= 1'b1;
            snoozing_q   <= 1'b0;
            led_q        <= 1'b1;
            ringIdx_q    <= matchIdx;
            timeoutCnt_q <= '0;
            snoozeCnt_q  <= '0;
            blinkCnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                RING: begin
                    if (dismiss_i || disarmHit) begin
                        state_q      <= IDLE;
                        ringing_q    <= 1'b0;
                        led_q        <= 1'b0;
                        timeoutCnt_q <= '0;
                        blinkCnt_q   <= '0;
                    end else if (snooze_i) begin
                        state_q      <= SNOOZE;
                        ringing_q    <= 1'b0;
                        snoozing_q   <= 1'b1;
                        led_q        <= 1'b0;
                        timeoutCnt_q <= '0;
                        snoozeCnt_q  <= SNOOZE_LOAD;
                        blinkCnt_q   <= '0;
                    end else if (min_tick_i && (timeoutCnt_q == TIMEOUT_LAST)) begin
                        state_q      <= IDLE;
                        ringing_q    <= 1'b0;
                        led_q        <= 1'b0;
                        timeoutCnt_q <= '0;
                        blinkCnt_q   <= '0;
                    end else begin
                        if (min_tick_i) begin
                            timeoutCnt_q <= timeoutCnt_q + 4'd1;
                        end
                        if (blinkCnt_q == BLINK_LAST) begin
                            blinkCnt_q <= '0;
                            led_q      <= ~led_q;
                        end else begin
                            blinkCnt_q <= blinkCnt_q + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss_i || disarmHit) begin
                        state_q     <= IDLE;
                        snoozing_q  <= 1'b0;
                        snoozeCnt_q <= '0;
                    end else if (min_tick_i && (snoozeCnt_q == 4'd1)) begin
                        state_q      <= RING;
                        ringing_q    <= 1'b1;
                        snoozing_q   <= 1'b0;
                        led_q        <= 1'b1;
                        timeoutCnt_q <= '0;
                        snoozeCnt_q  <= '0;
                        blinkCnt_q   <= '0;
                    end else if (min_tick_i) begin
                        snoozeCnt_q <= snoozeCnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    ringing_q    <= 1'b0;
                    snoozing_q   <= 1'b0;
                    led_q        <= 1'b0;
                    timeoutCnt_q <= '0;
                    snoozeCnt_q  <= '0;
                    blinkCnt_q   <= '0;
                end
            endcase
        end
    end

    assign armed_o     = armed_q;
    assign ringing_o   = ringing_q;
    assign snoozing_o  = snoozing_q;
    assign ring_idx_o  = ringIdx_q;
    assign led_alarm_o = led_q;
    assign wr_err_o    = wrErr_q;

endmodule

// File: tb/tb_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_alarm_bank
//
// Self-checking bench for alarm_bank with a short blink divider. A table of
// {stimulus, expected} vectors is applied in order; each vector's expected
// outputs are pushed to a scoreboard queue when driven and popped for
// comparison one clock later. Hand-written sequences cover snooze expiry,
// the unanswered-ring timeout, match preempting snooze and the LED blink.
// ---------------------------------------------------------------------------
module tb_alarm_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  HT, HU, MT, MU;
    logic        minTick;
    logic        wrEn;
    logic [1:0]  wrIdx;
    logic [15:0] wrTime;
    logic        wrArm;
    logic        snooze;
    logic        dismiss;
    logic [3:0]  armed;
    logic        ringing;
    logic        snoozing;
    logic [1:0]  ringIdx;
    logic        ledAlarm;
    logic        wrErr;

    typedef struct {
        logic        rstN;
        logic        tick;
        logic [15:0] now;
        logic        wrEn;
        logic [1:0]  wrIdx;
        logic [15:0] wrTime;
        logic        wrArm;
        logic        snz;
        logic        dis;
    } stim_t;

    typedef struct {
        logic [3:0] armed;
        logic       ring;
        logic       snzO;
        logic [1:0] idx;
        logic       idxCare;
        logic       led;
        logic       ledCare;
        logic       err;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecTable[$];
    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;

    alarm_bank #(
        .NUM_ALARMS(4),
        .IDX_W(2),
        .SNOOZE_MIN(5),
        .RING_TIMEOUT_MIN(10),
        .BLINK_DIV(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .HT_i(HT),
        .HU_i(HU),
        .MT_i(MT),
        .MU_i(MU),
        .min_tick_i(minTick),
        .wr_en_i(wrEn),
        .wr_idx_i(wrIdx),
        .wr_time_i(wrTime),
        .wr_arm_i(wrArm),
        .snooze_i(snooze),
        .dismiss_i(dismiss),
        .armed_o(armed),
        .ringing_o(ringing),
        .snoozing_o(snoozing),
        .ring_idx_o(ringIdx),
        .led_alarm_o(ledAlarm),
        .wr_err_o(wrErr)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the bench itself stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rstN, input logic tick, input logic [15:0] now,
                                input logic we, input logic [1:0] wi, input logic [15:0] wt,
                                input logic wa, input logic snz, input logic dis,
                                input logic [3:0] eArmed, input logic eRing, input logic eSnz,
                                input logic [1:0] eIdx, input logic idxCare,
                                input logic eLed, input logic ledCare, input logic eErr);
        vec_t v;
        v.s.rstN   = rstN;
        v.s.tick   = tick;
        v.s.now    = now;
        v.s.wrEn   = we;
        v.s.wrIdx  = wi;
        v.s.wrTime = wt;
        v.s.wrArm  = wa;
        v.s.snz    = snz;
        v.s.dis    = dis;
        v.e.armed   = eArmed;
        v.e.ring    = eRing;
        v.e.snzO    = eSnz;
        v.e.idx     = eIdx;
        v.e.idxCare = idxCare;
        v.e.led     = eLed;
        v.e.ledCare = ledCare;
        v.e.err     = eErr;
        return v;
    endfunction

    task automatic checkField(input string name, input int tag, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL vec%0d %s: got %0h expected %0h", tag, name, act, expv);
        end
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows.
    task automatic checkOutput(input int tag);
        exp_t e;
        if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL vec%0d scoreboard: got empty expected entry", tag);
        end else begin
            e = sbQueue.pop_front();
            checkField("armed", tag, armed, e.armed);
            checkField("ringing", tag, {3'b0, ringing}, {3'b0, e.ring});
            checkField("snoozing", tag, {3'b0, snoozing}, {3'b0, e.snzO});
            checkField("wr_err", tag, {3'b0, wrErr}, {3'b0, e.err});
            if (e.idxCare) begin
                checkField("ring_idx", tag, {2'b0, ringIdx}, {2'b0, e.idx});
            end
            if (e.ledCare) begin
                checkField("led_alarm", tag, {3'b0, ledAlarm}, {3'b0, e.led});
            end
        end
    endtask

    // Drives one vector just after a rising edge, queues its expectation and
    // checks it one cycle later.
    task automatic applyStimulus(input vec_t v, input int tag);
        rst     = v.s.rstN;
        minTick = v.s.tick;
        {HT, HU, MT, MU} = v.s.now;
        wrEn    = v.s.wrEn;
        wrIdx   = v.s.wrIdx;
        wrTime  = v.s.wrTime;
        wrArm   = v.s.wrArm;
        snooze  = v.s.snz;
        dismiss = v.s.dis;
        sbQueue.push_back(v.e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [11:0] blinkPat;
        int          tag;

        // rstN tick now wrEn wrIdx wrTime wrArm snz dis | armed ring snz idx idxCare led ledCare err
        vecTable.push_back(mk(0, 0, 16'h0729, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0729, 1, 1, 16'h0730, 1, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0729, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0730, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, 1, 0, 1, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0730, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, 1, 0, 1, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0730, 0, 0, 16'h0000, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0731, 0, 0, 16'h0000, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0731, 1, 0, 16'h0600, 1, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0731, 1, 2, 16'h0600, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0600, 0, 0, 16'h0000, 0, 0, 0, 4'b0111, 1, 0, 0, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 1, 1, 16'h2460, 1, 0, 0, 4'b0111, 1, 0, 0, 1, 1, 1, 1));
        vecTable.push_back(mk(1, 0, 16'h0600, 0, 0, 16'h0000, 0, 0, 0, 4'b0111, 1, 0, 0, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 0, 0, 16'h0000, 0, 0, 1, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 1, 3, 16'h0760, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0, 1, 1));
        vecTable.push_back(mk(1, 1, 16'h0730, 0, 0, 16'h0000, 0, 0, 0, 4'b0111, 1, 0, 1, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0730, 0, 0, 16'h0000, 0, 0, 1, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0600, 0, 0, 16'h0000, 0, 0, 0, 4'b0111, 1, 0, 0, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 0, 0, 16'h0000, 0, 1, 1, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0730, 0, 0, 16'h0000, 0, 0, 0, 4'b0111, 1, 0, 1, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0600, 0, 0, 16'h0000, 0, 0, 1, 4'b0111, 1, 0, 0, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 0, 0, 16'h0000, 0, 0, 1, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0600, 1, 3, 16'h1200, 1, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h1200, 0, 0, 16'h0000, 0, 0, 0, 4'b1111, 1, 0, 3, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h1200, 1, 3, 16'h1200, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h1200, 1, 3, 16'h1300, 1, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h1300, 0, 0, 16'h0000, 0, 0, 0, 4'b1111, 1, 0, 3, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h1300, 1, 3, 16'h1400, 1, 0, 0, 4'b1111, 1, 0, 3, 1, 1, 1, 0));
        vecTable.push_back(mk(0, 0, 16'h1300, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h1300, 1, 2, 16'h0000, 1, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h2359, 0, 0, 16'h0000, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b0100, 1, 0, 2, 1, 1, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 4'b0100, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h2359, 1, 0, 0, 4'b0101, 0, 0, 0, 0, 0, 1, 0));
        vecTable.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h1a00, 1, 0, 0, 4'b0101, 0, 0, 0, 0, 0, 1, 1));

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i], i);
        end

        // Ring slot 0, snooze, five ticks back to RING, then ten unanswered
        // ticks time it out.
        tag = 100;
        applyStimulus(mk(1, 1, 16'h2359, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 0, 1, 1, 1, 0), tag++);
        applyStimulus(mk(1, 0, 16'h2359, 0, 0, 16'h0000, 0, 1, 0, 4'b0101, 0, 1, 0, 1, 0, 1, 0), tag++);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mk(1, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 0, 1, 0, 1, 0, 1, 0), tag++);
        end
        applyStimulus(mk(1, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 0, 1, 1, 1, 0), tag++);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(mk(1, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 0, 1, 0, 0, 0), tag++);
        end
        applyStimulus(mk(1, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 0, 0, 0, 0, 0, 1, 0), tag++);

        // A new match while snoozed brings it straight back to RING on the
        // new slot.
        tag = 200;
        applyStimulus(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 2, 1, 1, 1, 0), tag++);
        applyStimulus(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 4'b0101, 0, 1, 2, 1, 0, 1, 0), tag++);
        applyStimulus(mk(1, 1, 16'h2359, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 0, 1, 1, 1, 0), tag++);
        applyStimulus(mk(1, 0, 16'h2359, 0, 0, 16'h0000, 0, 0, 1, 4'b0101, 0, 0, 0, 0, 0, 1, 0), tag++);

        // LED blink with a divider of four: 1111 0000 1111 from RING entry.
        tag = 300;
        blinkPat = 12'b1111_0000_1111;
        applyStimulus(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 2, 1, blinkPat[11], 1, 0), tag++);
        for (int k = 1; k < 12; k++) begin
            applyStimulus(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 4'b0101, 1, 0, 2, 1, blinkPat[11 - k], 1, 0), tag++);
        end
        applyStimulus(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 4'b0101, 0, 1, 2, 1, 0, 1, 0), tag++);
        applyStimulus(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 4'b0101, 0, 0, 0, 0, 0, 1, 0), tag++);

        if (sbQueue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbQueue.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
